// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU.
// A grant latches the winner's operands, the ALU result is captured one
// cycle later, and the result is held for the owner until it is consumed.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN. When it is defined, ties
// go to the requester that was not granted last. When it is undefined,
// requester 0 always wins a tie.
//
// state | meaning
// IDLE  | no operation in flight; grant a pending request
// EXEC  | operands are on the ALU; capture alu_result at the end of the cycle
// RESP  | result is presented to the owner until its rsp ready is seen
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srcA,
    input  logic [WIDTH-1:0] req0_srcB,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srcA,
    input  logic [WIDTH-1:0] req1_srcB,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             owner_q, owner_d;
    logic             gnt0, gnt1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Tie goes to whoever did not win last time; a lone request always wins.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_grant_q);
        gnt1 = req1_valid & ~gnt0;
    end

    // Remember the most recent winner for the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // The grant history only moves when a request is actually accepted.
    always_comb begin
        last_grant_d = last_grant_q;
        if (req0_ready) begin
            last_grant_d = 1'b0;
        end else if (req1_ready) begin
            last_grant_d = 1'b1;
        end
    end
`else
    // Fixed priority: requester 0 wins every tie.
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    // Ready only in IDLE, and the rst_n term keeps it low while reset is held.
    always_comb begin
        req0_ready = (state_q == IDLE) & rst_n & gnt0;
        req1_ready = (state_q == IDLE) & rst_n & gnt1;
    end

    // State, operand, result and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            srca_q   <= '0;
            srcb_q   <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            owner_q  <= owner_d;
        end
    end

    // Next-state logic: grant in IDLE, one EXEC cycle, hold RESP until the owner consumes.
    always_comb begin
        state_d  = state_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        owner_d  = owner_q;
        unique case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    srca_d  = req0_srcA;
                    srcb_d  = req0_srcB;
                    ctrl_d  = req0_ctrl;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (req1_ready) begin
                    srca_d  = req1_srcA;
                    srcb_d  = req1_srcB;
                    ctrl_d  = req1_ctrl;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                // A ready from the non-owner is ignored.
                if ((!owner_q && rsp0_ready) || (owner_q && rsp1_ready)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The response is visible only to the owner and only in RESP; everything else reads 0.
    always_comb begin
        rsp0_valid  = (state_q == RESP) & ~owner_q;
        rsp1_valid  = (state_q == RESP) & owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
    end

    // The shared ALU sees only the latched operands and never the live request ports.
    always_comb begin
        alu_srcA = srca_q;
        alu_srcB = srcb_q;
        alu_ctrl = ctrl_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It models the shared ALU and keeps a scoreboard
// of expected responses that is pushed on each grant and popped on each
// response. Expected grant order depends on ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_srcA, req0_srcB, req1_srcA, req1_srcB;
    logic [2:0]   req0_ctrl, req1_ctrl;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [W-1:0] alu_srcA, alu_srcB, alu_result;
    logic [2:0]   alu_ctrl;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srcA(req0_srcA), .req0_srcB(req0_srcB), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srcA(req1_srcA), .req1_srcB(req1_srcB), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b110:  return ~(a | b);
            default: return {a[15:0], b[15:0]};
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_srcA, alu_srcB, alu_ctrl);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_srcA = 32'h11; req0_srcB = 32'h22; req0_ctrl = 3'b000;
        req1_srcA = 32'h33; req1_srcB = 32'h44; req1_ctrl = 3'b001;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0)
            $display("FAIL reset_handshake: got %b expected 0000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        else passed++;
        total++;
        if ({rsp0_result, rsp1_result} !== 64'h0)
            $display("FAIL reset_results: got %h %h expected 0 0", rsp0_result, rsp1_result);
        else passed++;
        total++;
        if ({alu_srcA, alu_srcB, alu_ctrl} !== 67'h0)
            $display("FAIL reset_alu: got %h %h %b expected 0", alu_srcA, alu_srcB, alu_ctrl);
        else passed++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid, req0_ready} !== 3'b0)
            $display("FAIL reset_release: got %b expected 000", {rsp0_valid, rsp1_valid, req0_ready});
        else passed++;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0_srcA = 32'd10; req0_srcB = 32'd20; req0_ctrl = 3'b000; req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready});
        else passed++;
        if (req0_ready) exp_q.push_back('{owner: 1'b0, res: 32'd30});
        @(negedge clk);
        req0_valid = 1'b0; req0_srcA = 32'hdead; req0_srcB = 32'hbeef; req0_ctrl = 3'b011;
        #1;
        total++;
        if (rsp0_valid !== 1'b0)
            $display("FAIL single_latency: rsp0_valid got %b in EXEC expected 0", rsp0_valid);
        else passed++;
        total++;
        if ({alu_srcA, alu_srcB, alu_ctrl} !== {32'd10, 32'd20, 3'b000})
            $display("FAIL single_alu_regs: got %0d %0d %b expected 10 20 000", alu_srcA, alu_srcB, alu_ctrl);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid, rsp1_result} !== {2'b10, 32'h0})
            $display("FAIL single_rsp_valid: got %b %b %h expected 1 0 0", rsp0_valid, rsp1_valid, rsp1_result);
        else passed++;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL single_scoreboard: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            if (e.owner !== 1'b0 || rsp0_result !== e.res)
                $display("FAIL single_result: got %0d expected %0d", rsp0_result, e.res);
            else passed++;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        total++;
        if (rsp0_valid !== 1'b0)
            $display("FAIL single_release: rsp0_valid got %b expected 0", rsp0_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req1_srcA = 32'd30; req1_srcB = 32'd10; req1_ctrl = 3'b001; req1_valid = 1'b1;
        rsp1_ready = 1'b0;
        #1;
        total++;
        if (req1_ready !== 1'b1)
            $display("FAIL bp_grant: req1_ready got %b expected 1", req1_ready);
        else passed++;
        if (req1_ready) exp_q.push_back('{owner: 1'b1, res: 32'd20});
        @(negedge clk);
        req1_valid = 1'b0;
        req0_srcA = 32'd7; req0_srcB = 32'd8; req0_ctrl = 3'b000; req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({rsp1_valid, rsp1_result, req0_ready, rsp0_valid} !== {1'b1, 32'd20, 1'b0, 1'b0})
                $display("FAIL bp_hold%0d: got v=%b r=%0d rdy0=%b v0=%b expected 1 20 0 0",
                         i, rsp1_valid, rsp1_result, req0_ready, rsp0_valid);
            else passed++;
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        #1;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL bp_scoreboard: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            if (rsp1_valid !== 1'b1 || e.owner !== 1'b1 || rsp1_result !== e.res)
                $display("FAIL bp_result: got v=%b %0d expected 1 %0d", rsp1_valid, rsp1_result, e.res);
            else passed++;
        end
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        total++;
        if (req0_ready !== 1'b1)
            $display("FAIL bp_waiting_req: req0_ready got %b expected 1", req0_ready);
        else passed++;
        if (req0_ready) exp_q.push_back('{owner: 1'b0, res: 32'd15});
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rsp1_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            total++;
            if ({rsp0_valid, rsp1_valid} !== 2'b10)
                $display("FAIL bp_foreign_ready: got %b expected 10", {rsp0_valid, rsp1_valid});
            else passed++;
        end
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        #1;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL bp_scoreboard2: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            if (e.owner !== 1'b0 || rsp0_result !== e.res)
                $display("FAIL bp_result2: got %0d expected %0d", rsp0_result, e.res);
            else passed++;
        end
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_contention();
        int grants[4];
        int exp_grants[4];
        int ng = 0;
        int nr = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_grants = '{0, 1, 0, 1};
`else
        exp_grants = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        req0_srcA = 32'b1010; req0_srcB = 32'b1100; req0_ctrl = 3'b010;
        req1_srcA = 32'b1010; req1_srcB = 32'b1100; req1_ctrl = 3'b011;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            #1;
            if (req0_ready && req1_ready) begin
                total++;
                $display("FAIL cont_double_grant: got both ready expected one");
            end
            if (req0_ready) begin
                exp_q.push_back('{owner: 1'b0, res: 32'b1000});
                if (ng < 4) grants[ng] = 0;
                ng++;
            end else if (req1_ready) begin
                exp_q.push_back('{owner: 1'b1, res: 32'b1110});
                if (ng < 4) grants[ng] = 1;
                ng++;
            end
            if (rsp0_valid || rsp1_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL cont_scoreboard: got response with empty queue expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (rsp0_valid !== ~e.owner || rsp1_valid !== e.owner ||
                        (e.owner ? rsp1_result : rsp0_result) !== e.res)
                        $display("FAIL cont_rsp%0d: got v=%b%b r=%b/%b expected owner %0d %b",
                                 nr, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result, e.owner, e.res);
                    else passed++;
                end
                nr++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (nr != 4) $display("FAIL cont_timeout: got %0d responses expected 4", nr);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= ng || grants[i] != exp_grants[i])
                $display("FAIL cont_grant%0d: got %0d expected %0d", i, (i < ng) ? grants[i] : -1, exp_grants[i]);
            else passed++;
        end
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_slt_passthrough();
        logic [W-1:0] ta[5];
        logic [W-1:0] tb[5];
        logic [2:0]   tc[5];
        logic [W-1:0] te[5];
        ta = '{32'd5, 32'd15, 32'hffff_fffb, 32'h0000_0009, 32'h1234_5678};
        tb = '{32'd10, 32'd10, 32'd3, 32'h0000_0006, 32'h9abc_def0};
        tc = '{3'b101, 3'b101, 3'b101, 3'b100, 3'b111};
        te = '{32'd1, 32'd0, 32'd1, 32'h0000_000f, 32'h5678_def0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0_srcA = ta[i]; req0_srcB = tb[i]; req0_ctrl = tc[i]; req0_valid = 1'b1;
            #1;
            if (req0_ready) exp_q.push_back('{owner: 1'b0, res: te[i]});
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            total++;
            if (alu_ctrl !== tc[i])
                $display("FAIL op%0d_ctrl: got %b expected %b", i, alu_ctrl, tc[i]);
            else passed++;
            @(negedge clk);
            rsp0_ready = 1'b1;
            #1;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL op%0d_scoreboard: got empty queue expected entry", i);
            end else begin
                e = exp_q.pop_front();
                if (rsp0_valid !== 1'b1 || rsp0_result !== e.res)
                    $display("FAIL op%0d_result: got v=%b %h expected 1 %h", i, rsp0_valid, rsp0_result, e.res);
                else passed++;
            end
            @(negedge clk);
            rsp0_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        @(negedge clk);
        req0_srcA = 32'd1; req0_srcB = 32'd2; req0_ctrl = 3'b000; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
             alu_srcA, alu_srcB, alu_ctrl} !== '0)
            $display("FAIL midop_reset_outputs: got alu=%h/%h/%b v=%b%b expected all 0",
                     alu_srcA, alu_srcB, alu_ctrl, rsp0_valid, rsp1_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL midop_no_response: got %0d valid cycles expected 0", seen);
        else passed++;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        req1_srcA = 32'd3; req1_srcB = 32'd4; req1_ctrl = 3'b000; req1_valid = 1'b1;
        #1;
        if (req1_ready) exp_q.push_back('{owner: 1'b1, res: 32'd7});
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        rsp1_ready = 1'b1;
        #1;
        total++;
        if (exp_q.size() != 1) begin
            $display("FAIL midop_scoreboard: got %0d entries expected 1", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (rsp1_valid !== 1'b1 || rsp1_result !== e.res)
                $display("FAIL midop_new_op: got v=%b %0d expected 1 %0d", rsp1_valid, rsp1_result, e.res);
            else passed++;
        end
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_contention();
        test_slt_passthrough();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 Port: reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 Port: reqN_srcA, reqN_srcB  input  WIDTH  requester N operands.
REQ-007 Port: reqN_ctrl  input  3  requester N ALUControl code (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-008 Port: rspN_valid  output  1  result for requester N available.
REQ-009 Port: rspN_ready  input  1  requester N consumes the result.
REQ-010 Port: rspN_result  output  WIDTH  result for requester N.
REQ-011 Port: alu_srcA, alu_srcB  output  WIDTH  operands driven to the shared ALU.
REQ-012 Port: alu_ctrl  output  3  ALUControl driven to the shared ALU.
REQ-013 Port: alu_result  input  WIDTH  combinational result from the shared ALU.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; exactly one active.
REQ-015 IDLE: if any reqN_valid, reqN_ready SHALL be asserted (combinationally) for exactly one granted requester; on that edge its srcA/srcB/ctrl SHALL be latched into operand registers, owner recorded, state -> EXEC.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP, and 0 in IDLE for non-granted requesters.
REQ-017 alu_srcA/alu_srcB/alu_ctrl SHALL always be driven from the operand registers, never directly from request ports.
REQ-018 EXEC: alu_result SHALL be captured into the result register at the end of the cycle; state -> RESP (one EXEC cycle exactly).
REQ-019 RESP: rspN_valid SHALL be 1 only for the owner; rspN_result SHALL equal the result register, stable until handshake.
REQ-020 RESP with owner's rspN_ready=1: state -> IDLE next edge; otherwise hold RESP indefinitely.
REQ-021 rspN_result for the non-owner SHALL be 0; both rspN_valid SHALL be 0 outside RESP.
REQ-022 Latency: request accepted at edge T -> rsp_valid high from cycle T+2; minimum 3 cycles per operation.
REQ-023 Requests arriving in EXEC/RESP SHALL wait (not dropped); requesters hold valid and payload until ready.
REQ-024 ctrl codes 100/110/111 SHALL be passed through unchanged; result is whatever the ALU returns.
REQ-025 No arithmetic in the block; result width WIDTH, no truncation or extension.
REQ-026 A rspN_ready seen outside RESP, or from the non-owner, SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, operand/result registers 0, owner 0, last_grant 1.
REQ-028 During reset all outputs SHALL be 0 (reqN_ready, rspN_valid, rspN_result, alu_*).
REQ-029 Reset in EXEC or RESP SHALL abort the operation; no response is ever issued for it.

Configuration
REQ-030 Macro ALU_ARB_ROUND_ROBIN_EN defined: simultaneous requests granted to the requester not granted last (last_grant register, updated on each grant); single request granted regardless.
REQ-031 Macro undefined: fixed priority, requester 0 always wins ties; last_grant register not implemented.

Verification
REQ-032 Single op: req0 srcA=10, srcB=20, ctrl=000 at T -> rsp0_valid at T+2, rsp0_result=30, rsp1_valid=0.
REQ-033 Backpressure: req1 srcA=30, srcB=10, ctrl=001, rsp1_ready low 5 cycles -> rsp1_valid held, rsp1_result=20 stable, req0_ready=0 throughout.
REQ-034 Contention, RR_EN defined: both valid continuously (req0 0b1010&0b1100 ctrl=010, req1 0b1010|0b1100 ctrl=011) -> grants 0,1,0,1; results 0b1000, 0b1110 alternately.
REQ-035 Contention, RR_EN undefined: same stimulus -> only requester 0 granted while req0_valid stays high.
REQ-036 SLT: srcA=5, srcB=10, ctrl=101 -> result 1; srcA=15, srcB=10 -> result 0.
REQ-037 Reset mid-op: rst_n low during EXEC -> outputs 0 immediately; after release, no rsp_valid until a new request is accepted.
